instruction_prefetch_queue: RTL and testbench

Byte-granular circular prefetch queue between the bus/fetch unit and the decode stages. Accepts 1–4 little-endian instruction bytes per cycle from fetch. Presents a 16-byte window starting at the oldest unconsumed byte to the prefix/opcode decoders. Retires the byte count the decoders report as consumed each cycle. It is the producer end of the `i_instruction[0:15]` / consumed-bytes interface.

---
 rtl/prefetch_pkg.sv | 10 +
 rtl/prefetch_byte_ring.sv | 37 +++
 rtl/instruction_prefetch_queue.sv | 84 ++++++++
 tb/tb_instruction_prefetch_queue.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared sizing constants and pointer/count types for the instruction prefetch queue.
package prefetch_pkg;
  localparam int PREFETCH_DEPTH  = 32;
  localparam int WINDOW_BYTES    = 16;
  localparam int FETCH_MAX_BYTES = 4;
  localparam int PREFETCH_PTR_W  = $clog2(PREFETCH_DEPTH);

  typedef logic [PREFETCH_PTR_W-1:0] prefetch_ptr_t;
  typedef logic [PREFETCH_PTR_W:0]   prefetch_cnt_t;
endpackage

// File: rtl/prefetch_byte_ring.sv
// Byte ring storage: masked 4-byte write at the tail, 16-byte rotated read at the head.
// The read port is combinational; window bytes at or beyond rd_valid read as zero.
module prefetch_byte_ring
  import prefetch_pkg::*;
#(
  parameter int DEPTH = PREFETCH_DEPTH
) (
  input  logic                           clock,
  input  logic [FETCH_MAX_BYTES-1:0]     wr_mask,
  input  logic [$clog2(DEPTH)-1:0]       wr_ptr,
  input  logic [8*FETCH_MAX_BYTES-1:0]   wr_data,
  input  logic [$clog2(DEPTH)-1:0]       rd_ptr,
  input  logic [4:0]                     rd_valid,
  output logic [7:0]                     rd_data [0:WINDOW_BYTES-1]
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0] mem [0:DEPTH-1];

  // Pointer arithmetic is PW bits wide, so indices wrap modulo DEPTH for free.
  always_ff @(posedge clock) begin
    for (int j = 0; j < FETCH_MAX_BYTES; j++) begin
      if (wr_mask[j]) begin
        mem[wr_ptr + PW'(j)] <= wr_data[8*j +: 8];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < WINDOW_BYTES; k++) begin
      rd_data[k] = 8'h00;
      if (5'(k) < rd_valid) begin
        rd_data[k] = mem[rd_ptr + PW'(k)];
      end
    end
  end
endmodule

// File: rtl/instruction_prefetch_queue.sv
// Circular byte prefetch queue: fetch pushes 1-4 bytes per cycle, decode sees a 16-byte
// window at the oldest byte and retires a reported byte count; flush has top priority.
module instruction_prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int DEPTH = PREFETCH_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       i_flush,
  input  logic                       i_fetch_valid,
  input  logic [31:0]                i_fetch_data,
  input  logic [2:0]                 i_fetch_bytes,
  output logic                       o_fetch_ready,
  output logic [7:0]                 o_instruction [0:WINDOW_BYTES-1],
  output logic [4:0]                 o_valid_bytes,
  input  logic [4:0]                 i_consume_bytes,
  output logic                       o_error,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          error_q;

  logic          fetch_bytes_ok;
  logic          push_attempt;
  logic [2:0]    push_n;
  logic          consume_bad;
  logic [4:0]    consume_n;
  logic [FETCH_MAX_BYTES-1:0] wr_mask;

  // Ready depends only on registered occupancy, never on this cycle's consume.
  assign o_fetch_ready  = (count <= CW'(DEPTH - FETCH_MAX_BYTES));
  assign o_valid_bytes  = (count > CW'(WINDOW_BYTES)) ? 5'(WINDOW_BYTES) : count[4:0];
  assign o_count        = count;
  assign o_error        = error_q;

  assign fetch_bytes_ok = (i_fetch_bytes != 3'd0) && (i_fetch_bytes <= 3'(FETCH_MAX_BYTES));
  assign push_attempt   = i_fetch_valid & o_fetch_ready & ~i_flush;
  assign push_n         = (push_attempt && fetch_bytes_ok) ? i_fetch_bytes : 3'd0;
  assign consume_bad    = (i_consume_bytes > o_valid_bytes);
  assign consume_n      = consume_bad ? 5'd0 : i_consume_bytes;

  always_comb begin
    for (int j = 0; j < FETCH_MAX_BYTES; j++) begin
      wr_mask[j] = (3'(j) < push_n);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      error_q <= 1'b0;
    end else if (i_flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      error_q <= 1'b0;
    end else begin
      tail    <= tail + PW'(push_n);
      head    <= head + PW'(consume_n);
      count   <= count + CW'(push_n) - CW'(consume_n);
      error_q <= consume_bad | (push_attempt & ~fetch_bytes_ok);
    end
  end

  prefetch_byte_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clock    (clock),
    .wr_mask  (wr_mask),
    .wr_ptr   (tail),
    .wr_data  (i_fetch_data),
    .rd_ptr   (head),
    .rd_valid (o_valid_bytes),
    .rd_data  (o_instruction)
  );
endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Directed bench for instruction_prefetch_queue: push/consume/wrap/flush/error scenarios.
module tb_instruction_prefetch_queue;
  logic        clock;
  logic        reset_n;
  logic        i_flush;
  logic        i_fetch_valid;
  logic [31:0] i_fetch_data;
  logic [2:0]  i_fetch_bytes;
  logic        o_fetch_ready;
  logic [7:0]  o_instruction [0:15];
  logic [4:0]  o_valid_bytes;
  logic [4:0]  i_consume_bytes;
  logic        o_error;
  logic [5:0]  o_count;

  int checks = 0;
  int errors = 0;

  instruction_prefetch_queue #(.DEPTH(32)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .i_flush         (i_flush),
    .i_fetch_valid   (i_fetch_valid),
    .i_fetch_data    (i_fetch_data),
    .i_fetch_bytes   (i_fetch_bytes),
    .o_fetch_ready   (o_fetch_ready),
    .o_instruction   (o_instruction),
    .o_valid_bytes   (o_valid_bytes),
    .i_consume_bytes (i_consume_bytes),
    .o_error         (o_error),
    .o_count         (o_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    i_flush         = 1'b0;
    i_fetch_valid   = 1'b0;
    i_fetch_data    = 32'h0;
    i_fetch_bytes   = 3'd0;
    i_consume_bytes = 5'd0;
  endtask

  task automatic push(input logic [31:0] data, input logic [2:0] n);
    i_fetch_valid = 1'b1;
    i_fetch_data  = data;
    i_fetch_bytes = n;
    tick();
    idle();
  endtask

  task automatic consume(input logic [4:0] n);
    i_consume_bytes = n;
    tick();
    idle();
  endtask

  task automatic test_reset();
    logic any_nonzero;
    idle();
    reset_n = 1'b0;
    #12;
    checks++;
    if (o_count !== 6'd0 || o_valid_bytes !== 5'd0) begin
      errors++;
      $display("FAIL reset_count got cnt=%0d vb=%0d exp 0/0", o_count, o_valid_bytes);
    end
    checks++;
    if (o_fetch_ready !== 1'b1 || o_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got rdy=%b err=%b exp 1/0", o_fetch_ready, o_error);
    end
    any_nonzero = 1'b0;
    for (int k = 0; k < 16; k++) if (o_instruction[k] !== 8'h00) any_nonzero = 1'b1;
    checks++;
    if (any_nonzero) begin
      errors++;
      $display("FAIL reset_window got nonzero byte exp all 00 (byte0=%h)", o_instruction[0]);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_push_basic();
    logic [7:0] exp [0:3];
    exp = '{8'hF0, 8'h2E, 8'h66, 8'h0F};
    push(32'h0F662EF0, 3'd4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_instruction[k] !== exp[k]) begin
        errors++;
        $display("FAIL push_basic_byte%0d got %h exp %h", k, o_instruction[k], exp[k]);
      end
    end
    checks++;
    if (o_valid_bytes !== 5'd4 || o_count !== 6'd4) begin
      errors++;
      $display("FAIL push_basic_count got vb=%0d cnt=%0d exp 4/4", o_valid_bytes, o_count);
    end
    checks++;
    if (o_instruction[4] !== 8'h00) begin
      errors++;
      $display("FAIL push_basic_byte4 got %h exp 00", o_instruction[4]);
    end
  endtask

  task automatic test_full();
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      b = 8'(4 + 4 * i);
      push({b + 8'd3, b + 8'd2, b + 8'd1, b}, 3'd4);
    end
    checks++;
    if (o_count !== 6'd28 || o_fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_28 got cnt=%0d rdy=%b exp 28/1", o_count, o_fetch_ready);
    end
    push(32'h0000001C, 3'd1);
    checks++;
    if (o_count !== 6'd29 || o_fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_29 got cnt=%0d rdy=%b exp 29/0", o_count, o_fetch_ready);
    end
    push(32'hFFFFFFFF, 3'd4);
    checks++;
    if (o_count !== 6'd29 || o_error !== 1'b0) begin
      errors++;
      $display("FAIL full_blocked got cnt=%0d err=%b exp 29/0", o_count, o_error);
    end
    consume(5'd3);
    checks++;
    if (o_count !== 6'd26 || o_fetch_ready !== 1'b1 || o_valid_bytes !== 5'd16) begin
      errors++;
      $display("FAIL full_consume got cnt=%0d rdy=%b vb=%0d exp 26/1/16", o_count, o_fetch_ready, o_valid_bytes);
    end
    checks++;
    if (o_instruction[0] !== 8'h0F || o_instruction[1] !== 8'h04 || o_instruction[15] !== 8'h12) begin
      errors++;
      $display("FAIL full_window got %h %h %h exp 0f 04 12", o_instruction[0], o_instruction[1], o_instruction[15]);
    end
  endtask

  task automatic test_flush();
    i_flush         = 1'b1;
    i_fetch_valid   = 1'b1;
    i_fetch_data    = 32'h11223344;
    i_fetch_bytes   = 3'd4;
    i_consume_bytes = 5'd2;
    tick();
    idle();
    checks++;
    if (o_count !== 6'd0 || o_valid_bytes !== 5'd0 || o_error !== 1'b0) begin
      errors++;
      $display("FAIL flush got cnt=%0d vb=%0d err=%b exp 0/0/0", o_count, o_valid_bytes, o_error);
    end
    checks++;
    if (o_instruction[0] !== 8'h00 || o_fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_window got b0=%h rdy=%b exp 00/1", o_instruction[0], o_fetch_ready);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp [0:3];
    exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 7; i++) push(32'h5A5A5A5A, 3'd4);
    push(32'h00005A5A, 3'd2);
    consume(5'd16);
    consume(5'd14);
    checks++;
    if (o_count !== 6'd0 || o_error !== 1'b0) begin
      errors++;
      $display("FAIL wrap_drain got cnt=%0d err=%b exp 0/0", o_count, o_error);
    end
    push(32'hDDCCBBAA, 3'd4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_instruction[k] !== exp[k]) begin
        errors++;
        $display("FAIL wrap_byte%0d got %h exp %h", k, o_instruction[k], exp[k]);
      end
    end
  endtask

  task automatic test_simultaneous();
    push(32'h44332211, 3'd4);
    push(32'h00006655, 3'd2);
    checks++;
    if (o_count !== 6'd10 || o_instruction[5] !== 8'h22) begin
      errors++;
      $display("FAIL simul_setup got cnt=%0d b5=%h exp 10/22", o_count, o_instruction[5]);
    end
    i_fetch_valid   = 1'b1;
    i_fetch_data    = 32'hEE998877;
    i_fetch_bytes   = 3'd3;
    i_consume_bytes = 5'd5;
    tick();
    idle();
    checks++;
    if (o_count !== 6'd8 || o_error !== 1'b0) begin
      errors++;
      $display("FAIL simul_count got cnt=%0d err=%b exp 8/0", o_count, o_error);
    end
    checks++;
    if (o_instruction[0] !== 8'h22 || o_instruction[7] !== 8'h99 || o_instruction[8] !== 8'h00) begin
      errors++;
      $display("FAIL simul_window got %h %h %h exp 22 99 00", o_instruction[0], o_instruction[7], o_instruction[8]);
    end
  endtask

  task automatic test_over_consume();
    consume(5'd6);
    i_consume_bytes = 5'd3;
    tick();
    checks++;
    if (o_error !== 1'b1 || o_count !== 6'd2 || o_instruction[0] !== 8'h88) begin
      errors++;
      $display("FAIL over_consume got err=%b cnt=%0d b0=%h exp 1/2/88", o_error, o_count, o_instruction[0]);
    end
    i_consume_bytes = 5'd2;
    tick();
    idle();
    checks++;
    if (o_error !== 1'b0 || o_count !== 6'd0 || o_valid_bytes !== 5'd0) begin
      errors++;
      $display("FAIL over_consume_after got err=%b cnt=%0d vb=%0d exp 0/0/0", o_error, o_count, o_valid_bytes);
    end
    consume(5'd1);
    checks++;
    if (o_error !== 1'b1 || o_count !== 6'd0) begin
      errors++;
      $display("FAIL empty_consume got err=%b cnt=%0d exp 1/0", o_error, o_count);
    end
    tick();
    checks++;
    if (o_error !== 1'b0) begin
      errors++;
      $display("FAIL error_pulse got err=%b exp 0", o_error);
    end
  endtask

  task automatic test_illegal_fetch();
    push(32'h12345678, 3'd0);
    checks++;
    if (o_count !== 6'd0 || o_error !== 1'b1) begin
      errors++;
      $display("FAIL fetch_zero got cnt=%0d err=%b exp 0/1", o_count, o_error);
    end
    push(32'h12345678, 3'd5);
    checks++;
    if (o_count !== 6'd0 || o_error !== 1'b1) begin
      errors++;
      $display("FAIL fetch_five got cnt=%0d err=%b exp 0/1", o_count, o_error);
    end
    tick();
    checks++;
    if (o_error !== 1'b0) begin
      errors++;
      $display("FAIL fetch_err_clear got err=%b exp 0", o_error);
    end
  endtask

  task automatic test_reset_midop();
    push(32'hA3A2A1A0, 3'd4);
    reset_n = 1'b0;
    #2;
    checks++;
    if (o_count !== 6'd0 || o_valid_bytes !== 5'd0 || o_instruction[0] !== 8'h00) begin
      errors++;
      $display("FAIL reset_midop got cnt=%0d vb=%0d b0=%h exp 0/0/00", o_count, o_valid_bytes, o_instruction[0]);
    end
    @(negedge clock);
    reset_n       = 1'b1;
    i_fetch_valid = 1'b1;
    i_fetch_data  = 32'hB3B2B1B0;
    i_fetch_bytes = 3'd4;
    tick();
    idle();
    checks++;
    if (o_count !== 6'd4 || o_instruction[0] !== 8'hB0 || o_instruction[3] !== 8'hB3) begin
      errors++;
      $display("FAIL reset_first_push got cnt=%0d b0=%h b3=%h exp 4/b0/b3", o_count, o_instruction[0], o_instruction[3]);
    end
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_full();
    test_flush();
    test_wrap();
    test_simultaneous();
    test_over_consume();
    test_illegal_fetch();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
